// File: rtl/divider_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_types : shared types and constants for the RV32M divide unit.
//
// Contents
//   div_op_t     - divide operation, equal to funct3[1:0] of the instruction
//   div_state_t  - divider sequencing states
//   DIV_ITERS    - number of restoring iterations (one quotient bit each)
//   DIV_CNT_W    - width of the iteration counter
//   DIV_BY_ZERO_Q- quotient returned for a zero divisor
//   INT_MIN      - most negative 32-bit value (signed-overflow detection)
// ---------------------------------------------------------------------------
package rv32i_types;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DIVIDE = 2'b01,
        FINISH = 2'b10
    } div_state_t;

    localparam int          DIV_ITERS     = 32;
    localparam int          DIV_CNT_W     = $clog2(DIV_ITERS);
    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN       = 32'h8000_0000;

    // Signed ops are DIV and REM; both have funct3[0] clear.
    function automatic logic op_is_signed(input div_op_t op);
        return (op == DIV) || (op == REM);
    endfunction

    // REM and REMU return the remainder; DIV and DIVU the quotient.
    function automatic logic op_wants_rem(input div_op_t op);
        return (op == REM) || (op == REMU);
    endfunction

endpackage

// File: rtl/divider_step.sv
// ---------------------------------------------------------------------------
// div_step : one combinational radix-2 restoring division iteration.
//
// Ports
//   rem_in   [32:0] partial remainder before the step
//   dvd_in   [31:0] remaining dividend bits, MSB is consumed this step
//   quo_in   [31:0] partial quotient before the step
//   dvs      [31:0] divisor magnitude
//   rem_out  [32:0] partial remainder after the step
//   dvd_out  [31:0] dividend shifted left by one
//   quo_out  [31:0] partial quotient with the new bit shifted in
// ---------------------------------------------------------------------------
module div_step
    import rv32i_types::*;
(
    input  logic [32:0] rem_in,
    input  logic [31:0] dvd_in,
    input  logic [31:0] quo_in,
    input  logic [31:0] dvs,
    output logic [32:0] rem_out,
    output logic [31:0] dvd_out,
    output logic [31:0] quo_out
);

    logic [32:0] shifted;
    logic [32:0] diff;
    logic        fits;

    // The partial remainder stays below the divisor after every step, so
    // its top bit is always zero going in and only the low 32 bits shift up.
    logic unused_rem_msb;
    assign unused_rem_msb = rem_in[32];

    // Bring down the next dividend bit and try a 33-bit unsigned subtract;
    // keep the difference only when it does not underflow.
    always_comb begin
        shifted = {rem_in[31:0], dvd_in[31]};
        diff    = shifted - {1'b0, dvs};
        fits    = (shifted >= {1'b0, dvs});
        rem_out = fits ? diff : shifted;
        quo_out = {quo_in[30:0], fits};
        dvd_out = {dvd_in[30:0], 1'b0};
    end

endmodule

// File: rtl/divider.sv
// ---------------------------------------------------------------------------
// divider : multi-cycle RV32M integer divider (DIV, DIVU, REM, REMU).
//
// Radix-2 restoring division on operand magnitudes, one quotient bit per
// cycle, with signs reapplied at the end. Divide-by-zero and signed
// overflow bypass the iterations and finish on the following cycle.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      request, only honoured while idle
//   op         operation (div_op_t), sampled with start
//   a, b       dividend / divisor, sampled with start
//   busy       high whenever a request is in flight
//   done       one-cycle pulse, results valid in that cycle
//   quotient   registered quotient, held until the next completion
//   remainder  registered remainder, held until the next completion
//   result     quotient or remainder according to the accepted op
// ---------------------------------------------------------------------------
module divider
    import rv32i_types::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  div_op_t          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic [WIDTH-1:0] result
);

    div_state_t           state;
    div_op_t              op_q;
    logic [32:0]          rem_q;
    logic [31:0]          dvd_q;
    logic [31:0]          quo_q;
    logic [31:0]          dvs_q;
    logic [DIV_CNT_W-1:0] cnt;
    logic                 neg_quo_q;
    logic                 neg_rem_q;
    logic                 special_q;

    logic                 in_signed;
    logic                 sign_a;
    logic                 sign_b;
    logic [31:0]          abs_a;
    logic [31:0]          abs_b;
    logic                 div_zero;
    logic                 overflow;

    logic [32:0]          step_rem;
    logic [31:0]          step_dvd;
    logic [31:0]          step_quo;

    // Decode the incoming request. The magnitude of INT_MIN wraps back to
    // 0x80000000, which is exactly right once treated as unsigned.
    always_comb begin
        in_signed = op_is_signed(op);
        sign_a    = in_signed & a[31];
        sign_b    = in_signed & b[31];
        abs_a     = sign_a ? (32'd0 - a) : a;
        abs_b     = sign_b ? (32'd0 - b) : b;
        div_zero  = (b == 32'd0);
        overflow  = in_signed && (a == INT_MIN) && (b == 32'hFFFF_FFFF);
    end

    div_step u_step (
        .rem_in  (rem_q),
        .dvd_in  (dvd_q),
        .quo_in  (quo_q),
        .dvs     (dvs_q),
        .rem_out (step_rem),
        .dvd_out (step_dvd),
        .quo_out (step_quo)
    );

    // Sequencer: accept in IDLE, iterate in DIVIDE, fix up signs and
    // publish in FINISH. Special requests preload their final answers and
    // FINISH passes them through untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_q      <= DIV;
            rem_q     <= '0;
            dvd_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            cnt       <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            special_q <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q      <= op;
                        dvd_q     <= abs_a;
                        dvs_q     <= abs_b;
                        neg_quo_q <= sign_a ^ sign_b;
                        neg_rem_q <= sign_a;
                        cnt       <= '0;
                        if (div_zero || overflow) begin
                            special_q <= 1'b1;
                            quo_q     <= div_zero ? DIV_BY_ZERO_Q : INT_MIN;
                            rem_q     <= div_zero ? {1'b0, a} : 33'd0;
                            state     <= FINISH;
                        end else begin
                            special_q <= 1'b0;
                            quo_q     <= '0;
                            rem_q     <= '0;
                            state     <= DIVIDE;
                        end
                    end
                end
                DIVIDE: begin
                    rem_q <= step_rem;
                    dvd_q <= step_dvd;
                    quo_q <= step_quo;
                    cnt   <= cnt + 1'b1;
                    if (cnt == DIV_CNT_W'(DIV_ITERS - 1)) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    if (special_q) begin
                        quotient  <= quo_q;
                        remainder <= rem_q[31:0];
                    end else begin
                        quotient  <= neg_quo_q ? (32'd0 - quo_q) : quo_q;
                        remainder <= neg_rem_q ? (32'd0 - rem_q[31:0]) : rem_q[31:0];
                    end
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs derived from state and the registered results.
    always_comb begin
        busy   = (state != IDLE);
        result = op_wants_rem(op_q) ? remainder : quotient;
    end

endmodule

// File: tb/tb_divider.sv
// ---------------------------------------------------------------------------
// tb_divider : self-checking bench for the RV32M divider.
// ---------------------------------------------------------------------------
module tb_divider;
    import rv32i_types::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    div_op_t     op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic [31:0] result;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    divider #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .result    (result)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    endtask

    // Reference behaviour from the RISC-V rules using plain arithmetic.
    task automatic refModel(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                            output logic [31:0] q, output logic [31:0] r, output int lat);
        logic sgn;
        sgn = (o == 2'b00) || (o == 2'b10);
        lat = 34;
        if (y == 32'd0) begin
            q = 32'hFFFF_FFFF; r = x; lat = 2;
        end else if (sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = 32'd0; lat = 2;
        end else if (sgn) begin
            q = $signed(x) / $signed(y);
            r = $signed(x) % $signed(y);
        end else begin
            q = x / y;
            r = x % y;
        end
    endtask

    // Issue one request from just after a clock edge and wait for done.
    // Returns latency in cycles from acceptance (-1 on timeout) and the
    // number of in-flight cycles where busy was unexpectedly low.
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                 output int lat, output int busy_err);
        start = 1'b1; op = div_op_t'(o); a = x; b = y;
        lat = -1; busy_err = 0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin
                start = 1'b0;
                op = div_op_t'($urandom_range(0, 3)); a = $urandom; b = $urandom;
            end
            if (done) begin
                lat = n;
                break;
            end
            if (!busy) busy_err++;
        end
    endtask

    task automatic runAndCheck(input string tag, input logic [1:0] o, input logic [31:0] x,
                               input logic [31:0] y, input logic [31:0] eq, input logic [31:0] er,
                               input int elat);
        int lat, berr;
        applyStimulus(o, x, y, lat, berr);
        checkOutput({tag, " latency"}, 32'(lat), 32'(elat));
        checkOutput({tag, " busy"}, 32'(berr), 32'd0);
        checkOutput({tag, " quotient"}, quotient, eq);
        checkOutput({tag, " remainder"}, remainder, er);
        checkOutput({tag, " result"}, result, o[1] ? er : eq);
    endtask

    initial begin
        int lat, berr, stray;
        logic [31:0] eq, er;
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        int          elat;

        vecs[0]  = '{2'b01, 32'd100,        32'd7,          32'd14,         32'd2,          34};
        vecs[1]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  34};
        vecs[2]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  34};
        vecs[3]  = '{2'b11, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  2};
        vecs[4]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          2};
        vecs[5]  = '{2'b01, 32'hFFFF_FFFF,  32'h0001_0000,  32'h0000_FFFF,  32'h0000_FFFF,  34};
        vecs[6]  = '{2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          34};
        vecs[7]  = '{2'b10, 32'hFFFF_FFF8,  32'hFFFF_FFFD,  32'd2,          32'hFFFF_FFFE,  34};
        vecs[8]  = '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  34};
        vecs[9]  = '{2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          2};
        vecs[10] = '{2'b00, 32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0,          34};
        vecs[11] = '{2'b11, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          34};

        rst = 1'b1; start = 1'b0; op = DIV; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset done", {31'd0, done}, 32'd0);
        checkOutput("reset quotient", quotient, 32'd0);
        checkOutput("reset remainder", remainder, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed table.
        for (int i = 0; i < 12; i++) begin
            runAndCheck($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                        vecs[i].q, vecs[i].r, vecs[i].lat);
            @(posedge clk); #1;
            checkOutput($sformatf("vec%0d done pulse", i), {31'd0, done}, 32'd0);
        end

        // Starts during busy are ignored; reissue in the done cycle.
        start = 1'b1; op = DIVU; a = 32'hFFFF_FFFF; b = 32'h0001_0000;
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            start = (n >= 5 && n <= 20) ? n[0] : 1'b0;
            if (start) begin
                op = div_op_t'($urandom_range(0, 3)); a = $urandom; b = $urandom_range(0, 9);
            end
            if (done) begin
                lat = n;
                break;
            end
        end
        checkOutput("ignored-start latency", 32'(lat), 32'd34);
        checkOutput("ignored-start quotient", quotient, 32'h0000_FFFF);
        checkOutput("ignored-start remainder", remainder, 32'h0000_FFFF);
        start = 1'b1; op = DIVU; a = 32'd1000; b = 32'd10;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("back-to-back done low", {31'd0, done}, 32'd0);
        checkOutput("back-to-back busy", {31'd0, busy}, 32'd1);
        checkOutput("result hold", quotient, 32'h0000_FFFF);
        lat = -1;
        for (int n = 2; n <= 100; n++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = n;
                break;
            end
        end
        checkOutput("back-to-back latency", 32'(lat), 32'd34);
        checkOutput("back-to-back quotient", quotient, 32'd100);
        checkOutput("back-to-back remainder", remainder, 32'd0);
        @(posedge clk); #1;

        // Reset while dividing drops the request.
        start = 1'b1; op = DIV; a = 32'd1000; b = 32'd3;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("midreset busy", {31'd0, busy}, 32'd0);
        checkOutput("midreset done", {31'd0, done}, 32'd0);
        checkOutput("midreset quotient", quotient, 32'd0);
        checkOutput("midreset remainder", remainder, 32'd0);
        rst = 1'b0;
        stray = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) stray++;
        end
        checkOutput("midreset no done", 32'(stray), 32'd0);
        runAndCheck("after reset 9/3", 2'b00, 32'd9, 32'd3, 32'd3, 32'd0, 34);
        @(posedge clk); #1;

        // Randomised requests against the reference model.
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                3: rb = 32'hFFFF_FFFF;
                4: begin ra = 32'($urandom_range(0, 50)); rb = $urandom; end
                default: rb = $urandom;
            endcase
            refModel(ro, ra, rb, eq, er, elat);
            runAndCheck($sformatf("rand%0d op%0d %08h/%08h", i, ro, ra, rb), ro, ra, rb, eq, er, elat);
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
